// File: rtl/emb_decode_if.sv
// Decode-layer bus: run/valid handshake, flat vector/id buses and the embedding ROM read port.
// master = host/ROM side, slave = emb_decode_layer.
interface emb_decode_if #(
  parameter int N        = 10,
  parameter int CHAR_LEN = 8,
  parameter int EMB_DIM  = 24,
  parameter int N_LEN    = 16
);
  logic                            run;
  logic [N*EMB_DIM*N_LEN-1:0]      d;
  logic                            rom_en;
  logic [CHAR_LEN-1:0]             rom_addr;
  logic [EMB_DIM*N_LEN-1:0]        rom_data;
  logic                            valid;
  logic [N*CHAR_LEN-1:0]           q;

  modport master (output run, d, rom_data, input rom_en, rom_addr, valid, q);
  modport slave  (input run, d, rom_data, output rom_en, rom_addr, valid, q);
endinterface

// File: rtl/emb_decode_layer.sv
// Argmax-of-dot-product decoder: per position, id of the embedding row closest to the input vector.
// Latency N*CHAR_NUM+3 cycles from run to valid; run is ignored while busy, result held until next run.
module emb_decode_layer #(
  parameter int N        = 10,
  parameter int CHAR_LEN = 8,
  parameter int CHAR_NUM = 200,
  parameter int EMB_DIM  = 24,
  parameter int N_LEN    = 16
) (
  input logic         clk,
  input logic         rst,
  emb_decode_if.slave bus
);
  localparam int VEC_W  = EMB_DIM * N_LEN;
  localparam int PW     = (N > 1) ? $clog2(N) : 1;
  localparam int PROD_W = 2 * N_LEN;
  localparam int DOT_W  = 2 * N_LEN + 5;
  localparam logic [PW-1:0]       P_LAST = PW'(N - 1);
  localparam logic [CHAR_LEN-1:0] C_LAST = CHAR_LEN'(CHAR_NUM - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic   issue, load_d, res_vld;

  logic [N*VEC_W-1:0]  d_buf;
  logic [PW-1:0]       p_cnt;
  logic [CHAR_LEN-1:0] c_cnt;
  logic                issue_last;

  // tags travel with each read: s0 = address issued, rd = ROM data present, s1 = dot registered
  logic                rom_en_r;
  logic [CHAR_LEN-1:0] rom_addr_r;
  logic [PW-1:0]       s0_p, rd_p, s1_p;
  logic [CHAR_LEN-1:0] s0_c, rd_c, s1_c;
  logic                rd_vld, s1_vld;

  logic signed [N_LEN-1:0]  a, b;
  logic signed [PROD_W-1:0] prod;
  logic signed [DOT_W-1:0]  dot, s1_dot, best_dot;
  logic [CHAR_LEN-1:0]      best_id, win_id;
  logic                     take, last_retire;
  logic [N*CHAR_LEN-1:0]    q_r;

  assign issue_last  = (p_cnt == P_LAST) && (c_cnt == C_LAST);
  assign last_retire = s1_vld && (s1_p == P_LAST) && (s1_c == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DRAIN waits for the final tag to retire so DONE and the last q write land together
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.run) state_nxt = ISSUE;
      ISSUE:   if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (last_retire) state_nxt = DONE;
      DONE:    if (bus.run) state_nxt = ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue   = 1'b0;
    load_d  = 1'b0;
    res_vld = 1'b0;
    case (state)
      IDLE:  load_d = bus.run;
      ISSUE: issue = 1'b1;
      DONE: begin
        load_d  = bus.run;
        res_vld = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_buf <= '0;
      p_cnt <= '0;
      c_cnt <= '0;
    end else if (load_d) begin
      d_buf <= bus.d;
      p_cnt <= '0;
      c_cnt <= '0;
    end else if (issue) begin
      if (c_cnt == C_LAST) begin
        c_cnt <= '0;
        p_cnt <= p_cnt + 1'b1;
      end else begin
        c_cnt <= c_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_en_r   <= 1'b0;
      rom_addr_r <= '0;
      s0_p       <= '0;
      s0_c       <= '0;
      rd_vld     <= 1'b0;
      rd_p       <= '0;
      rd_c       <= '0;
    end else begin
      rom_en_r <= issue;
      if (issue) rom_addr_r <= c_cnt;
      s0_p     <= p_cnt;
      s0_c     <= c_cnt;
      rd_vld   <= rom_en_r;
      rd_p     <= s0_p;
      rd_c     <= s0_c;
    end
  end

  // full-precision signed dot product; 24 products of 32 bits cannot overflow 37 bits
  always_comb begin
    a    = '0;
    b    = '0;
    prod = '0;
    dot  = '0;
    for (int j = 0; j < EMB_DIM; j++) begin
      a    = d_buf[int'(rd_p)*VEC_W + j*N_LEN +: N_LEN];
      b    = bus.rom_data[j*N_LEN +: N_LEN];
      prod = a * b;
      dot  = dot + DOT_W'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_p   <= '0;
      s1_c   <= '0;
      s1_dot <= '0;
    end else begin
      s1_vld <= rd_vld;
      s1_p   <= rd_p;
      s1_c   <= rd_c;
      s1_dot <= dot;
    end
  end

  // strict greater-than keeps the lowest id on ties
  assign take   = (s1_c == '0) || (s1_dot > best_dot);
  assign win_id = take ? s1_c : best_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_dot <= '0;
      best_id  <= '0;
      q_r      <= '0;
    end else if (s1_vld) begin
      if (take) begin
        best_dot <= s1_dot;
        best_id  <= s1_c;
      end
      if (s1_c == C_LAST) q_r[int'(s1_p)*CHAR_LEN +: CHAR_LEN] <= win_id;
    end
  end

  assign bus.rom_en   = rom_en_r;
  assign bus.rom_addr = rom_addr_r;
  assign bus.valid    = res_vld;
  assign bus.q        = q_r;
endmodule

// File: tb/tb_emb_decode_layer.sv
// Directed frames with randomized data, checked against a brute-force argmax reference.
module tb_emb_decode_layer;
  localparam int N        = 10;
  localparam int CHAR_LEN = 8;
  localparam int CHAR_NUM = 200;
  localparam int EMB_DIM  = 24;
  localparam int N_LEN    = 16;
  localparam int VEC_W    = EMB_DIM * N_LEN;
  localparam int D_W      = N * VEC_W;
  localparam int Q_W      = N * CHAR_LEN;
  localparam int LATENCY  = N * CHAR_NUM + 3;

  logic clk = 1'b0;
  logic rst;

  emb_decode_if #(.N(N), .CHAR_LEN(CHAR_LEN), .EMB_DIM(EMB_DIM), .N_LEN(N_LEN)) bus ();

  emb_decode_layer #(.N(N), .CHAR_LEN(CHAR_LEN), .CHAR_NUM(CHAR_NUM), .EMB_DIM(EMB_DIM), .N_LEN(N_LEN))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [VEC_W-1:0] rom_mem [256];

  always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom_mem[bus.rom_addr];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // exhaustive argmax over all rows with 64-bit integer arithmetic; first maximum wins
  function automatic logic [Q_W-1:0] ref_decode(input logic [D_W-1:0] dv);
    logic [Q_W-1:0] r;
    longint best, s;
    int best_c;
    shortint x, w;
    r = '0;
    for (int p = 0; p < N; p++) begin
      best   = 0;
      best_c = 0;
      for (int c = 0; c < CHAR_NUM; c++) begin
        s = 0;
        for (int j = 0; j < EMB_DIM; j++) begin
          x = dv[(p*EMB_DIM + j)*N_LEN +: N_LEN];
          w = rom_mem[c][j*N_LEN +: N_LEN];
          s = s + longint'(x) * longint'(w);
        end
        if (c == 0 || s > best) begin
          best   = s;
          best_c = c;
        end
      end
      r[p*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(best_c);
    end
    return r;
  endfunction

  function automatic logic [D_W-1:0] rand_d();
    logic [D_W-1:0] r;
    for (int k = 0; k < N*EMB_DIM; k++) r[k*N_LEN +: N_LEN] = N_LEN'($urandom);
    return r;
  endfunction

  function automatic void rom_clear();
    for (int c = 0; c < 256; c++) rom_mem[c] = '0;
  endfunction

  // waits for valid, optionally re-pulsing run mid-frame, then checks latency and result
  task automatic wait_result(input string tag, input logic [Q_W-1:0] exp_q,
                             input int rerun_at, input logic [D_W-1:0] dre);
    int cyc;
    bit seen;
    logic [CHAR_LEN-1:0] id;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < LATENCY + 100) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.run = (cyc == rerun_at);
      if (cyc == rerun_at) bus.d = dre;
      seen = bus.valid;
    end
    check({tag, "_latency"}, 128'(cyc), 128'(LATENCY));
    check({tag, "_q"}, 128'(bus.q), 128'(exp_q));
    for (int p = 0; p < N; p++) begin
      id = bus.q[p*CHAR_LEN +: CHAR_LEN];
      check({tag, "_id_range"}, 128'(id < CHAR_NUM), 128'(1));
    end
  endtask

  task automatic run_frame(input string tag, input logic [D_W-1:0] dv,
                           input int rerun_at, input logic [D_W-1:0] dre);
    logic [Q_W-1:0] exp_q;
    exp_q = ref_decode(dv);
    @(posedge clk);
    #1 bus.run = 1'b1;
    bus.d = dv;
    @(posedge clk);
    #1 bus.run = 1'b0;
    bus.d = rand_d();
    check({tag, "_valid_clr"}, 128'(bus.valid), 128'(0));
    wait_result(tag, exp_q, rerun_at, dre);
  endtask

  logic [D_W-1:0] dv, dv2;
  logic [VEC_W-1:0] row;

  initial begin
    rst          = 1'b1;
    bus.run      = 1'b0;
    bus.d        = '0;
    bus.rom_data = '0;
    rom_clear();
    #3;
    check("rst_valid", 128'(bus.valid), 128'(0));
    check("rst_q", 128'(bus.q), 128'(0));
    check("rst_rom_en", 128'(bus.rom_en), 128'(0));
    check("rst_rom_addr", 128'(bus.rom_addr), 128'(0));
    #10 rst = 1'b0;

    // ramp rows: only element0 matters, so other d elements are random
    rom_clear();
    for (int c = 0; c < CHAR_NUM; c++) rom_mem[c][N_LEN-1:0] = N_LEN'(c);
    dv = rand_d();
    for (int p = 0; p < N; p++) dv[p*VEC_W +: N_LEN] = N_LEN'(1);
    run_frame("ramp_pos", dv, -1, '0);
    check("ramp_pos_all199", 128'(bus.q), 128'({N{8'd199}}));
    dv = rand_d();
    for (int p = 0; p < N; p++) dv[p*VEC_W +: N_LEN] = '1;
    run_frame("ramp_neg", dv, -1, '0);
    check("ramp_neg_all0", 128'(bus.q), 128'(0));

    rom_clear();
    run_frame("zero_rom_tie", rand_d(), -1, '0);
    check("zero_rom_all0", 128'(bus.q), 128'(0));

    // equal-norm distinct two-hot rows; each position selects its own row exactly
    rom_clear();
    for (int c = 0; c < CHAR_NUM; c++) begin
      rom_mem[c][(c % EMB_DIM)*N_LEN +: N_LEN] = N_LEN'(100);
      rom_mem[c][((c % EMB_DIM + c / EMB_DIM + 1) % EMB_DIM)*N_LEN +: N_LEN] = N_LEN'(100);
    end
    for (int p = 0; p < N; p++) begin
      row = rom_mem[17*p + 3];
      dv[p*VEC_W +: VEC_W] = row;
    end
    run_frame("twohot", dv, -1, '0);
    for (int p = 0; p < N; p++)
      check("twohot_pos", 128'(bus.q[p*CHAR_LEN +: CHAR_LEN]), 128'(17*p + 3));

    rom_clear();
    for (int j = 0; j < EMB_DIM; j++) rom_mem[5][j*N_LEN +: N_LEN] = 16'h8000;
    for (int k = 0; k < N*EMB_DIM; k++) dv[k*N_LEN +: N_LEN] = 16'h8000;
    run_frame("overflow", dv, -1, '0);
    check("overflow_all5", 128'(bus.q), 128'({N{8'd5}}));

    for (int c = 0; c < 256; c++)
      for (int j = 0; j < EMB_DIM; j++) rom_mem[c][j*N_LEN +: N_LEN] = N_LEN'($urandom);
    run_frame("random", rand_d(), -1, '0);

    // run at cycle 100 must be ignored; then run in DONE starts a fresh frame
    dv  = rand_d();
    dv2 = rand_d();
    run_frame("busy_run", dv, 99, dv2);
    run_frame("done_run", dv2, -1, '0);

    dv = rand_d();
    @(posedge clk);
    #1 bus.run = 1'b1;
    bus.d = dv;
    @(posedge clk);
    #1 bus.run = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("mid_rom_en_busy", 128'(bus.rom_en), 128'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(bus.valid), 128'(0));
    check("mid_rst_q", 128'(bus.q), 128'(0));
    check("mid_rst_rom_en", 128'(bus.rom_en), 128'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_rom_en", 128'(bus.rom_en), 128'(0));
    check("post_rst_valid", 128'(bus.valid), 128'(0));
    run_frame("after_rst", rand_d(), -1, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
